// File: rtl/osc_pkg.sv
// Shared types and constants for the sample-to-UART framing path.
// Holds the frame sync byte, sample width, FSM state encoding and a saturating counter helper.
package osc_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         SAMPLE_W  = 24;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SYNC = 3'd2,
        B2   = 3'd3,
        B1   = 3'd4,
        B0   = 3'd5
    } frame_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as start(0), 8 data bits LSB first, stop(1); each bit lasts DIV clocks.
// done_o marks the final stop-bit cycle, last_o the cycle before it (DIV must be >= 2).
module uart_tx_byte #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       last_o
);

    localparam int             CW    = $clog2(DIV);
    localparam logic [CW-1:0]  LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  PRE   = CW'(DIV - 2);

    logic          active_q, active_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          start_ok_s;

    assign done_o     = active_q && (bit_q == 4'd9) && (baud_q == LAST);
    assign last_o     = active_q && (bit_q == 4'd9) && (baud_q == PRE);
    // A new byte may start while idle or in the final stop cycle, giving back-to-back bytes.
    assign start_ok_s = start_i && (!active_q || done_o);
    assign tx_o       = tx_q;

    // Bit sequencing and baud timing
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        tx_d     = tx_q;
        if (start_ok_s) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = 4'd0;
            data_d   = data_i;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_q == LAST) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    tx_d  = (bit_q <= 4'd7) ? data_q[bit_q[2:0]] : 1'b1;
                end
            end else begin
                baud_d = baud_q + CW'(1);
            end
        end else begin
            tx_d = 1'b1;
        end
    end

    // Serialiser state registers; line idles high in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            data_q   <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/sample_frame_tx.sv
// Buffers 24-bit ADC samples in a small FIFO and sends each as a 4-byte UART frame
// (A5, sample[23:16], [15:8], [7:0]) with frames streamed back-to-back while data is queued.
module sample_frame_tx
    import osc_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ready,
    output logic                tx,
    output logic                busy,
    output logic [7:0]          drop_count
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;

    logic                rst_meta_q, rst_sync_q;
    logic                ready_en_q;
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]          drop_q, drop_d;
    frame_state_e        state_q, state_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                empty_s, full_s, push_s, pop_s, flush_s;
    logic                start_s, byte_done_s, byte_last_s;
    logic [7:0]          byte_s;

    // Reset deassertion synchroniser; assertion stays asynchronous
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign empty_s      = (wptr_q == rptr_q);
    assign full_s       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign sample_ready = enable && !full_s && ready_en_q;
    assign push_s       = sample_valid && sample_ready;
    assign busy         = (state_q != IDLE) || !empty_s;
    assign drop_count   = drop_q;

    // FIFO pointer and drop-counter next state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        drop_d = drop_q;
        if (flush_s) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_s) wptr_d = wptr_q + PW'(1);
            else        wptr_d = wptr_q;
            if (pop_s)  rptr_d = rptr_q + PW'(1);
            else        rptr_d = rptr_q;
        end
        if (enable && sample_valid && full_s) drop_d = sat_inc8(drop_q);
        else                                  drop_d = drop_q;
    end

    // Frame sequencer; B0 hands over to LOAD one cycle early so the next sync byte follows without a gap
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop_s   = 1'b0;
        flush_s = 1'b0;
        start_s = 1'b0;
        byte_s  = 8'h00;
        case (state_q)
            IDLE: begin
                if (enable && !empty_s) state_d = LOAD;
                else if (!enable)       flush_s = 1'b1;
                else                    state_d = IDLE;
            end
            LOAD: begin
                if (enable && !empty_s) begin
                    pop_s   = 1'b1;
                    hold_d  = mem_q[rptr_q[AW-1:0]];
                    start_s = 1'b1;
                    byte_s  = SYNC_BYTE;
                    state_d = SYNC;
                end else begin
                    flush_s = !enable;
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (byte_done_s) begin
                    start_s = 1'b1;
                    byte_s  = hold_q[23:16];
                    state_d = B2;
                end else begin
                    state_d = SYNC;
                end
            end
            B2: begin
                if (byte_done_s) begin
                    start_s = 1'b1;
                    byte_s  = hold_q[15:8];
                    state_d = B1;
                end else begin
                    state_d = B2;
                end
            end
            B1: begin
                if (byte_done_s) begin
                    start_s = 1'b1;
                    byte_s  = hold_q[7:0];
                    state_d = B0;
                end else begin
                    state_d = B1;
                end
            end
            B0: begin
                if (byte_last_s && enable && !empty_s) begin
                    state_d = LOAD;
                end else if (byte_done_s) begin
                    if (enable && !empty_s) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                        flush_s = !enable;
                    end
                end else begin
                    state_d = B0;
                end
            end
            default: begin
                state_d = IDLE;
                flush_s = 1'b1;
            end
        endcase
    end

    // Control state registers, cleared by the synchronised reset
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            ready_en_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            drop_q     <= 8'h00;
            state_q    <= IDLE;
            hold_q     <= '0;
        end else begin
            ready_en_q <= 1'b1;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
        end
    end

    // Sample storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wptr_q[AW-1:0]] <= sample_data;
        else        mem_q[wptr_q[AW-1:0]] <= mem_q[wptr_q[AW-1:0]];
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_byte (
        .clk     (clk),
        .rst_n   (rst_sync_q),
        .start_i (start_s),
        .data_i  (byte_s),
        .tx_o    (tx),
        .done_o  (byte_done_s),
        .last_o  (byte_last_s)
    );

endmodule

// File: tb/tb_sample_frame_tx.sv
// Directed bench for sample_frame_tx at DIV=10: frame format, latency, burst/drop,
// enable drop mid-frame, asynchronous reset mid-byte and drop-counter saturation.
module tb_sample_frame_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_valid;
    logic [23:0] sample_data;
    logic        sample_ready;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    sample_frame_tx #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .tx           (tx),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Receive one byte sampling mid-bit on falling edges; gap = falling edges until start seen.
    task automatic rx_byte(input logic [7:0] exp, input int exp_gap, input string tag);
        int         n;
        logic [7:0] b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 2000);
        if (exp_gap >= 0) chk({tag, " gap"}, n, exp_gap);
        else              chk({tag, " start seen"}, {31'd0, (n < 2000)}, 32'd1);
        repeat (5) @(negedge clk);
        chk({tag, " start bit"}, {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = tx;
        end
        chk({tag, " data"}, {24'd0, b}, {24'd0, exp});
        repeat (10) @(negedge clk);
        chk({tag, " stop bit"}, {31'd0, tx}, 32'd1);
    endtask

    task automatic rx_frame(input logic [23:0] s, input int first_gap, input string tag);
        rx_byte(8'hA5, first_gap, {tag, " sync"});
        rx_byte(s[23:16], 5, {tag, " b2"});
        rx_byte(s[15:8], 5, {tag, " b1"});
        rx_byte(s[7:0], 5, {tag, " b0"});
    endtask

    initial begin
        logic [23:0] burst [6];
        logic        ready_exp [6];
        int          lows;
        int          n;
        burst[0] = 24'hA1B2C3; burst[1] = 24'h00FF00; burst[2] = 24'h5A5A5A;
        burst[3] = 24'hFFFFFF; burst[4] = 24'h000000; burst[5] = 24'h7E8001;
        ready_exp[0] = 1'b1; ready_exp[1] = 1'b1; ready_exp[2] = 1'b1;
        ready_exp[3] = 1'b1; ready_exp[4] = 1'b1; ready_exp[5] = 1'b0;

        reset = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample_data = 24'h000000;
        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset ready", {31'd0, sample_ready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset drop", {24'd0, drop_count}, 32'd0);

        // Release: ready only after the synchroniser has settled
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready after 2 edges", {31'd0, sample_ready}, 32'd0);
        @(negedge clk);
        chk("ready after 3 edges", {31'd0, sample_ready}, 32'd1);

        // Single sample: latency and frame format
        sample_valid = 1'b1; sample_data = 24'h123456;
        @(negedge clk);
        sample_valid = 1'b0; sample_data = 24'hDEAD00;
        chk("busy after accept", {31'd0, busy}, 32'd1);
        rx_frame(24'h123456, 2, "single");
        repeat (4) @(negedge clk);
        chk("busy last stop cycle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy after frame", {31'd0, busy}, 32'd0);
        chk("tx idle after frame", {31'd0, tx}, 32'd1);

        // Burst of six: five accepted, one dropped, five contiguous frames
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    sample_valid = 1'b1; sample_data = burst[i];
                    chk($sformatf("burst ready %0d", i), {31'd0, sample_ready}, {31'd0, ready_exp[i]});
                    @(negedge clk);
                end
                sample_valid = 1'b0;
            end
            begin
                rx_frame(burst[0], 3, "burst f0");
                for (int f = 1; f < 5; f++) rx_frame(burst[f], 5, $sformatf("burst f%0d", f));
            end
        join
        repeat (5) @(negedge clk);
        chk("burst busy done", {31'd0, busy}, 32'd0);
        chk("burst drop", {24'd0, drop_count}, 32'd1);

        // Enable dropped during B2 with two samples queued
        fork
            begin
                sample_valid = 1'b1; sample_data = 24'h0F1E2D;
                @(negedge clk); sample_data = 24'h3C4B5A;
                @(negedge clk); sample_data = 24'h697887;
                @(negedge clk); sample_valid = 1'b0;
                repeat (150) @(negedge clk);
                enable = 1'b0;
                #1 chk("ready after enable drop", {31'd0, sample_ready}, 32'd0);
            end
            rx_frame(24'h0F1E2D, 3, "endrop");
        join
        repeat (5) @(negedge clk);
        chk("endrop tx idle", {31'd0, tx}, 32'd1);
        chk("endrop busy", {31'd0, busy}, 32'd0);
        chk("endrop ready", {31'd0, sample_ready}, 32'd0);
        lows = 0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        chk("endrop no further frame", lows, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("endrop fifo discarded", {31'd0, busy}, 32'd0);
        chk("endrop drop unchanged", {24'd0, drop_count}, 32'd1);

        // Reset pulse in the middle of the sync byte (data bit 4 of A5 is 0)
        sample_valid = 1'b1; sample_data = 24'hABCDEF;
        @(negedge clk); sample_data = 24'h111111;
        @(negedge clk); sample_valid = 1'b0;
        repeat (56) @(negedge clk);
        chk("mid sync tx low", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async reset tx", {31'd0, tx}, 32'd1);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset ready", {31'd0, sample_ready}, 32'd0);
        chk("async reset drop", {24'd0, drop_count}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset fifo empty", {31'd0, busy}, 32'd0);
        chk("post reset tx", {31'd0, tx}, 32'd1);
        sample_valid = 1'b1; sample_data = 24'h000001;
        @(negedge clk);
        sample_valid = 1'b0;
        rx_frame(24'h000001, 2, "post reset");
        repeat (5) @(negedge clk);
        chk("post reset idle", {31'd0, busy}, 32'd0);

        // Drop counter saturation with FIFO held full
        sample_valid = 1'b1;
        for (int i = 0; i < 205; i++) begin
            sample_data = 24'(i);
            @(negedge clk);
        end
        chk("drop before saturation", {24'd0, drop_count}, 32'd200);
        for (int i = 0; i < 105; i++) begin
            sample_data = 24'(i + 1000);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("drop saturated", {24'd0, drop_count}, 32'd255);
        repeat (3) @(negedge clk);
        chk("drop holds", {24'd0, drop_count}, 32'd255);
        chk("full ready low", {31'd0, sample_ready}, 32'd0);
        chk("full busy", {31'd0, busy}, 32'd1);

        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("final drain to idle", {31'd0, busy}, 32'd0);
        chk("final tx idle", {31'd0, tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
